alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage_pkg.sv | 24 ++
 rtl/alu_result_stage_cond_eval.sv | 35 +++
 rtl/alu_result_stage.sv | 72 +++++++
 tb/tb_alu_result_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: shared condition codes, flag bit indices and skid-buffer state encodings
package alu_result_stage_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} state_t;
endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// cond_eval: combinational evaluation of a 4-bit condition code against NZVC flags
module cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, v, c;
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry skid buffer for ALU results plus flags register and condition evaluation.
// Optional ALU_RESULT_FLAG_BYPASS_EN: cond_pass sees flags being written in the same cycle.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_result,
  input  logic [3:0]   in_flags_n_z_v_c,
  input  logic         in_set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags_n_z_v_c,
  output logic [3:0]   flags_reg_n_z_v_c,
  input  logic [3:0]   cond,
  output logic         cond_pass
);
  state_t state, state_next;
  logic [N-1:0] skid_result;
  logic [3:0] skid_flags, eval_flags;
  logic accept, consume;
  assign accept = in_valid & in_ready;
  assign consume = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_EMPTY;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: state_next = accept ? ST_ONE : ST_EMPTY;
      ST_ONE:   state_next = (accept & !consume) ? ST_TWO : (consume & !accept) ? ST_EMPTY : ST_ONE;
      ST_TWO:   state_next = consume ? ST_ONE : ST_TWO;
      default:  state_next = ST_EMPTY;
    endcase
  end
  always_comb begin
    out_valid = state != ST_EMPTY;
    in_ready = state != ST_TWO;
  end
  // Head takes the input when empty or when the old head leaves the same cycle; otherwise the input skids.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_result <= '0;
      out_flags_n_z_v_c <= '0;
      skid_result <= '0;
      skid_flags <= '0;
      flags_reg_n_z_v_c <= '0;
    end else begin
      if (state == ST_TWO && consume) begin
        out_result <= skid_result;
        out_flags_n_z_v_c <= skid_flags;
      end else if (accept && (state == ST_EMPTY || consume)) begin
        out_result <= in_result;
        out_flags_n_z_v_c <= in_flags_n_z_v_c;
      end else if (accept) begin
        skid_result <= in_result;
        skid_flags <= in_flags_n_z_v_c;
      end
      if (accept && in_set_flags) flags_reg_n_z_v_c <= in_flags_n_z_v_c;
    end
`ifdef ALU_RESULT_FLAG_BYPASS_EN
  assign eval_flags = (accept & in_set_flags) ? in_flags_n_z_v_c : flags_reg_n_z_v_c;
`else
  assign eval_flags = flags_reg_n_z_v_c;
`endif
  cond_eval u_cond_eval (.cond(cond), .flags(eval_flags), .pass(cond_pass));
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed self-checking bench for alu_result_stage (N=8)
module tb_alu_result_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, in_set_flags = 1'b0;
  logic [7:0] in_result = '0, out_result;
  logic [3:0] in_flags_n_z_v_c = '0, out_flags_n_z_v_c, flags_reg_n_z_v_c, cond = '0;
  logic       out_valid, out_ready = 1'b0, cond_pass;
  int n_cmp = 0, n_err = 0;
  alu_result_stage #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_flags_n_z_v_c(in_flags_n_z_v_c), .in_set_flags(in_set_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_flags_n_z_v_c(out_flags_n_z_v_c),
    .flags_reg_n_z_v_c(flags_reg_n_z_v_c), .cond(cond), .cond_pass(cond_pass)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags_n_z_v_c, 0);
    chk("rst_flags_reg", flags_reg_n_z_v_c, 0);
    rst = 1'b0;
    tick();
    in_valid = 1; in_result = 8'h0F; in_flags_n_z_v_c = 4'b0000; in_set_flags = 1; out_ready = 1;
    tick();
    in_valid = 0;
    chk("single_valid", out_valid, 1);
    chk("single_result", out_result, 8'h0F);
    chk("single_flags_reg", flags_reg_n_z_v_c, 4'b0000);
    tick();
    chk("single_drain", out_valid, 0);
    out_ready = 0; in_set_flags = 0;
    in_valid = 1; in_result = 8'h01;
    tick();
    in_result = 8'h03;
    tick();
    in_valid = 0;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_result, 8'h01);
    tick();
    chk("bp_hold", out_result, 8'h01);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1;
    tick();
    chk("bp_second", out_result, 8'h03);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    in_valid = 1; in_result = 8'h04;
    tick();
    in_valid = 0; out_ready = 0;
    chk("sim_valid", out_valid, 1);
    chk("sim_result", out_result, 8'h04);
    chk("sim_in_ready", in_ready, 1);
    out_ready = 1;
    tick();
    chk("sim_drain", out_valid, 0);
    in_valid = 1; in_result = 8'hAA; in_flags_n_z_v_c = 4'b0100; in_set_flags = 1; cond = 4'd0;
    #1;
`ifdef ALU_RESULT_FLAG_BYPASS_EN
    chk("bypass_eq", cond_pass, 1);
`else
    chk("nobypass_eq", cond_pass, 0);
`endif
    tick();
    in_valid = 0;
    chk("z_flags_reg", flags_reg_n_z_v_c, 4'b0100);
    chk("z_out_flags", out_flags_n_z_v_c, 4'b0100);
    #1 chk("z_eq", cond_pass, 1);
    cond = 4'd1;
    #1 chk("z_ne", cond_pass, 0);
    in_valid = 1; in_result = 8'h55; in_flags_n_z_v_c = 4'b1000; in_set_flags = 0;
    tick();
    in_valid = 0;
    chk("noset_flags_reg", flags_reg_n_z_v_c, 4'b0100);
    chk("noset_out_flags", out_flags_n_z_v_c, 4'b1000);
    cond = 4'd15;
    #1 chk("nv", cond_pass, 0);
    cond = 4'd14;
    #1 chk("al", cond_pass, 1);
    in_valid = 1; in_flags_n_z_v_c = 4'b1010; in_set_flags = 1;
    tick();
    in_valid = 0;
    chk("nv_flags_reg", flags_reg_n_z_v_c, 4'b1010);
    cond = 4'd10;
    #1 chk("ge", cond_pass, 1);
    cond = 4'd11;
    #1 chk("lt", cond_pass, 0);
    cond = 4'd12;
    #1 chk("gt", cond_pass, 1);
    cond = 4'd13;
    #1 chk("le", cond_pass, 0);
    cond = 4'd8;
    #1 chk("hi", cond_pass, 0);
    cond = 4'd9;
    #1 chk("ls", cond_pass, 1);
    cond = 4'd4;
    #1 chk("mi", cond_pass, 1);
    cond = 4'd3;
    #1 chk("cc", cond_pass, 1);
    out_ready = 0; in_valid = 1; in_result = 8'h11; in_flags_n_z_v_c = 4'b0011;
    tick();
    in_result = 8'h22;
    tick();
    in_valid = 0;
    chk("pre_rst_in_ready", in_ready, 0);
    chk("pre_rst_flags", flags_reg_n_z_v_c, 4'b0011);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_flags_reg", flags_reg_n_z_v_c, 0);
    chk("arst_out_result", out_result, 0);
    tick();
    rst = 0;
    out_ready = 1; in_valid = 1; in_result = 8'h5A; in_set_flags = 0;
    tick();
    in_valid = 0;
    chk("post_rst_result", out_result, 8'h5A);
    chk("post_rst_flags_reg", flags_reg_n_z_v_c, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
